// File: rtl/mmio_mon_pkg.sv
// ============================================================================
// Module      : mmio_mon_pkg
// Description : Shared types and constants for the MMIO bus monitor: state
//               encoding, drop counter width, default window/halt addresses
//               and the log entry width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_mon_pkg;

  // Monitor state encoding; TIMEOUT is only reachable with the watchdog built in
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } mon_state_e;

  // Width of the saturating dropped-capture counter
  localparam int DROP_CNT_W = 16;

  // Default MMIO window and halt trigger
  localparam logic [31:0] DEF_MMIO_BASE = 32'h0000_0800;
  localparam logic [31:0] DEF_MMIO_MASK = 32'h0000_0800;
  localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_0FFC;

  // A log entry is {address, data}
  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_log_fifo.sv
// ============================================================================
// Module      : mmio_log_fifo
// Description : First-word-fall-through synchronous FIFO. The head entry is
//               visible on pop_data whenever empty is low; a push into a full
//               FIFO is accepted only when a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign w_do_push = push && (!full || w_do_pop);
  assign level     = level_q;
  // Drive zeros when empty so the head never shows stale contents
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];

  // Next storage, pointers and occupancy; pointers wrap by natural overflow
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Register storage and bookkeeping; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_bus_monitor.sv
// ============================================================================
// Module      : mmio_bus_monitor
// Description : Passive core/memory bus snooper. Logs writes that hit the
//               MMIO window into a FWFT FIFO drained over a valid/ready port,
//               counts dropped captures and raises a sticky flag on an access
//               to the halt address.
//               Optional macro MMIO_MON_WATCHDOG_EN adds a cycle watchdog that
//               stops capturing after TIMEOUT_CYCLES cycles in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bus_monitor
  import mmio_mon_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE      = ADDR_W'(DEF_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK      = ADDR_W'(DEF_MMIO_MASK),
  parameter logic [ADDR_W-1:0] HALT_ADDR      = ADDR_W'(DEF_HALT_ADDR),
  parameter int                FIFO_DEPTH     = 8,
  parameter int                TIMEOUT_CYCLES = 4000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             bus_address,
  input  logic [DATA_W-1:0]             bus_data,
  input  logic                          bus_we,
  output logic                          log_valid,
  input  logic                          log_ready,
  output logic [ADDR_W-1:0]             log_addr,
  output logic [DATA_W-1:0]             log_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [DROP_CNT_W-1:0]         drop_count,
  output logic                          halted,
  output logic                          timeout
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);

  mon_state_e              state_q, state_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_count_q, drop_count_d;
  logic                    w_run;
  logic                    w_win_hit;
  logic                    w_halt_hit;
  logic                    w_capture;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;
  logic [ENTRY_W-1:0]      w_head;

  assign w_win_hit  = ((bus_address & MMIO_MASK) == (MMIO_BASE & MMIO_MASK));
  assign w_halt_hit = (bus_address == HALT_ADDR);
  assign w_capture  = w_run && bus_we && w_win_hit && !w_halt_hit;
  assign w_pop      = !w_empty && log_ready;
  assign w_drop     = w_capture && w_full && !w_pop;

  mmio_log_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_capture),
    .push_data ({bus_address, bus_data}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  assign log_valid            = !w_empty;
  assign {log_addr, log_data} = w_head;

`ifdef MMIO_MON_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            w_wd_expire;

  assign w_wd_expire = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles spent in RUN and freezes once the block leaves it
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (w_run) wd_cnt_d = wd_cnt_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state: halt beats watchdog expiry; HALTED and TIMEOUT are terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (w_halt_hit) begin
          state_d = ST_HALTED;
        end
`ifdef MMIO_MON_WATCHDOG_EN
        else if (w_wd_expire) begin
          state_d = ST_TIMEOUT;
        end
`endif
      end
      ST_HALTED:  state_d = ST_HALTED;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  // State-derived outputs
  always_comb begin
    w_run  = (state_q == ST_RUN);
    halted = (state_q == ST_HALTED);
`ifdef MMIO_MON_WATCHDOG_EN
    timeout = (state_q == ST_TIMEOUT);
`else
    timeout = 1'b0;
`endif
  end

  // Sticky overflow and saturating drop counter
  always_comb begin
    overflow_d   = overflow_q | w_drop;
    drop_count_d = drop_count_q;
    if (w_drop && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
  end

  // Overflow bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_monitor.sv
// ============================================================================
// Module      : tb_mmio_bus_monitor
// Description : Self-checking bench for mmio_bus_monitor. A queue-based
//               reference model tracks the log, overflow, drop count and
//               halt/timeout flags; directed scenarios are followed by random
//               bus traffic. Watchdog scenarios are included when
//               MMIO_MON_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_bus_monitor;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 50;
  localparam logic [31:0] BASE  = 32'h0000_0800;
  localparam logic [31:0] MASK  = 32'h0000_0800;
  localparam logic [31:0] HALT  = 32'h0000_0FFC;

  logic          clk;
  logic          reset;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data;
  logic          bus_we;
  logic          log_valid;
  logic          log_ready;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_data;
  logic [3:0]    level;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          halted;
  logic          timeout;

  mmio_bus_monitor #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MMIO_BASE      (BASE),
    .MMIO_MASK      (MASK),
    .HALT_ADDR      (HALT),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_address (bus_address),
    .bus_data    (bus_data),
    .bus_we      (bus_we),
    .log_valid   (log_valid),
    .log_ready   (log_ready),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .halted      (halted),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] mq[$];
  bit          m_ovf;
  int          m_drop;
  bit          m_halt;
  bit          m_tmo;
  int          m_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit run, cap, pop;
    if (reset) begin
      mq.delete();
      m_ovf  = 0;
      m_drop = 0;
      m_halt = 0;
      m_tmo  = 0;
      m_cnt  = 0;
      return;
    end
    run = !m_halt && !m_tmo;
    cap = run && bus_we && ((bus_address & MASK) == (BASE & MASK)) && (bus_address != HALT);
    pop = (mq.size() > 0) && log_ready;
    if (run) begin
      if (bus_address == HALT) m_halt = 1;
`ifdef MMIO_MON_WATCHDOG_EN
      else if (m_cnt == TMO - 1) m_tmo = 1;
      m_cnt++;
`endif
    end
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back({bus_address, bus_data});
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    chk("log_valid", log_valid, mq.size() > 0);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
    chk("halted", halted, m_halt);
    chk("timeout", timeout, m_tmo);
    if (mq.size() > 0) begin
      chk("log_addr", log_addr, mq[0][63:32]);
      chk("log_data", log_data, mq[0][31:0]);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare away from the edge
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input bit we,
                     input bit rdy, input bit rs);
    reset       = rs;
    bus_address = a;
    bus_data    = d;
    bus_we      = we;
    log_ready   = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(32'h0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    bus_address = '0;
    bus_data    = '0;
    bus_we      = 1'b0;
    log_ready   = 1'b0;

    // Reset state
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_log_addr", log_addr, 32'h0);
    chk("reset_log_data", log_data, 32'h0);

    // Two in-window writes, drained in order
    cyc(32'h800, 32'h11, 1'b1, 1'b1, 1'b0);
    chk("first_visible", {log_addr, log_data}, {32'h800, 32'h11});
    cyc(32'h804, 32'h22, 1'b1, 1'b1, 1'b0);
    chk("second_visible", {log_addr, log_data}, {32'h804, 32'h22});
    idle(2, 1'b1);
    chk("drained_level", level, 4'd0);

    // Out-of-window write and in-window read are ignored
    cyc(32'h100, 32'h55, 1'b1, 1'b1, 1'b0);
    cyc(32'h800, 32'h66, 1'b0, 1'b1, 1'b0);
    chk("ignored_valid", log_valid, 1'b0);

    // Overflow: 10 writes into a depth-8 FIFO with no drain
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc(32'h800 + 32'(4 * i), 32'(i + 1), 1'b1, 1'b0, 1'b0);
    chk("full_level", level, 4'd8);
    chk("full_overflow", overflow, 1'b1);
    chk("full_drops", drop_count, 16'd2);

    // Full with capture and pop on the same edge: nothing dropped
    cyc(32'h840, 32'hAA, 1'b1, 1'b1, 1'b0);
    chk("pushpop_level", level, 4'd8);
    chk("pushpop_drops", drop_count, 16'd2);
    idle(10, 1'b1);

    // Halt while entries pending; later writes ignored, entries still drain
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(32'h810 + 32'(4 * i), 32'hB0 + 32'(i), 1'b1, 1'b0, 1'b0);
    cyc(HALT, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("halt_set", halted, 1'b1);
    chk("halt_not_logged", level, 4'd3);
    for (int i = 0; i < 3; i++)
      cyc(32'h820 + 32'(4 * i), 32'hC0, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("halt_cleared", halted, 1'b0);

`ifdef MMIO_MON_WATCHDOG_EN
    // Watchdog expiry after TMO cycles in RUN
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(TMO - 1, 1'b0);
    chk("wd_before", timeout, 1'b0);
    idle(1, 1'b0);
    chk("wd_expired", timeout, 1'b1);
    // Halt on the expiry edge takes priority
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(TMO - 1, 1'b0);
    cyc(HALT, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wd_halt_prio_h", halted, 1'b1);
    chk("wd_halt_prio_t", timeout, 1'b0);
`endif

    // Random traffic against the model
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 99);
      if (sel < 60)      a = 32'h800 | ($urandom & 32'h7FC);
      else if (sel < 98) a = $urandom & 32'hFFFF_F7FF;
      else               a = HALT;
      cyc(a, $urandom, ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmio_bus_monitor.md
Name: mmio_bus_monitor

Overview:
- Synthesizable successor to the simulation-only bus watcher: snoops the core↔memory bus (address, write data, we) with no effect on the bus.
- Captures writes that fall in a parametrised MMIO window into a FIFO. The FIFO drains over a valid/ready log port.
- Detects a parametrised halt address and raises a sticky halt flag, replacing the hard-coded 0xFFC stop and the bit-11 print filter.
- Sits beside core/memory in tb and FPGA top levels; feeds a UART/console drain or a bench checker.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- MMIO_BASE, 32'h0000_0800, window match value.
- MMIO_MASK, 32'h0000_0800, window mask. Hit when (addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK).
- HALT_ADDR, 32'h0000_0FFC, halt trigger address.
- FIFO_DEPTH, 8, log entries; power of two, ≥2.
- TIMEOUT_CYCLES, 4000, watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- bus_address  in  ADDR_W  core address bus.
- bus_data  in  DATA_W  core write data (core data_out).
- bus_we  in  1  core write enable.
- log_valid  out  1  FIFO head valid.
- log_ready  in  1  consumer accepts head.
- log_addr  out  ADDR_W  head entry address.
- log_data  out  DATA_W  head entry data.
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: at least one capture dropped.
- drop_count  out  16  dropped captures, saturates at 16'hFFFF.
- halted  out  1  sticky halt flag.
- timeout  out  1  sticky watchdog flag (tied 0 without the optional feature).

Behaviour:
- Reset (synchronous): FIFO empty, log_valid=0, log_addr=0, log_data=0, level=0, overflow=0, drop_count=0, halted=0, timeout=0, state=RUN.
- Capture condition, sampled at posedge: state==RUN && bus_we && window hit && bus_address!=HALT_ADDR.
- An access to HALT_ADDR is never logged, even when it lies in the window.
- FIFO is first-word-fall-through:
  - A capture at edge N into an empty FIFO gives log_valid=1 with that entry during cycle N+1.
  - Capture-to-output latency is 1 cycle.
- Pop: log_valid && log_ready at a posedge. The next entry, or empty, is visible the following cycle.
- Push and pop on the same edge: both happen and level is unchanged. This applies when full too: the pop frees the slot, so the push is accepted and nothing is dropped.
- Full with no pop and a capture: the entry is discarded, overflow←1, drop_count increments (saturating). FIFO contents are untouched.
- Pointers wrap modulo FIFO_DEPTH. level distinguishes full from empty.
- Entries stay in order; log outputs are stable while log_valid && !log_ready.
- State machine:
  - RUN→HALTED when bus_address==HALT_ADDR at a posedge, read or write. halted=1 from the next cycle.
  - HALTED is terminal until reset.
  - No captures occur in HALTED; the FIFO keeps draining normally.
- Reset while entries are pending or halted: everything returns to reset values; pending entries are lost.
- Simultaneous reset with capture or pop: reset wins.

Optional Feature:
- Macro MMIO_MON_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in RUN and clears on reset.
  - When it reaches TIMEOUT_CYCLES-1, the next state is TIMEOUT: timeout=1 sticky, captures stop, the FIFO still drains.
  - Halt detection on the same edge takes priority: the block goes to HALTED, not TIMEOUT.
- Undefined: no counter, no TIMEOUT state, timeout tied to 0.

Decomposition:
- Package mmio_mon_pkg holds:
  - state encoding (RUN, HALTED, TIMEOUT);
  - log entry width constant (ADDR_W+DATA_W);
  - drop counter width (16);
  - default window and halt constants.
- One sub-module, mmio_log_fifo: parametrised FWFT synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/level.
- Window match, halt detection, state machine and drop counter live in the top.

Test Plan:
- Reset, then writes 0x800←0x11, 0x804←0x22, log_ready=1 → log entries (0x800,0x11) then (0x804,0x22) in order; each visible 1 cycle after its write; level returns to 0.
- Write 0x100←0x55, read 0x800 with bus_we=0 → no log_valid, level=0.
- log_ready=0, 10 window writes with FIFO_DEPTH=8 → level=8, overflow=1, drop_count=2; drain yields the first 8 data values in order.
- FIFO full, capture and pop on the same edge → level stays 8, drop_count unchanged, new entry appears last.
- Write 0xFFC←0x1 while 3 entries pending → halted=1 next cycle, 0xFFC not logged, later window writes ignored, 3 entries still drain; reset clears halted.
- With MMIO_MON_WATCHDOG_EN and TIMEOUT_CYCLES=50, no halt access → timeout=1 at cycle 50 after reset; a halt access on that same edge instead gives halted=1, timeout=0.
